// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   state_e      : control FSM state encodings (also exported on the debug State port)
//   ALU_*        : ALUop encodings, consumed unchanged by ALUControl
//   OP_*         : IR[31:26] opcode constants
//   ctrl_t       : bundle of all Moore-decoded datapath controls
//   imm_alu_op() : ALUop for an I-type arithmetic/logic opcode
//   decode_ctrl(): Moore output decode for one state and latched opcode
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_FUNC = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_LUI  = 4'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       sign_extend;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

    function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
        logic [3:0] r;
        case (op)
            OP_ANDI: r = ALU_AND;
            OP_ORI:  r = ALU_OR;
            OP_SLTI: r = ALU_SLT;
            OP_LUI:  r = ALU_LUI;
            default: r = ALU_ADD;   // addi / addiu
        endcase
        return r;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                // PCWrite/IRWrite are added in the top, gated by MemReady
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                // ALU precomputes PC + (sext(imm) << 2) for a possible branch
                c.alu_src_b   = 2'd3;
                c.sign_extend = 1'b1;
                c.alu_op      = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'd2;
                c.sign_extend = 1'b1;
                c.alu_op      = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNC;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'd1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            S_IEXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'd2;
                c.alu_op      = imm_alu_op(op);
                // logical immediates are zero-extended
                c.sign_extend = !((op == OP_ANDI) || (op == OP_ORI));
            end
            S_IWB: begin
                c.reg_write = 1'b1;
            end
            S_TRAP: begin
                c.trap = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state and opcode dispatch for multi_cycle_control.
// Ports:
//   state_i      current state encoding
//   opcode_i     live IR opcode (used for the DECODE dispatch)
//   opcode_q_i   opcode latched in DECODE (used to pick lw/sw after MEMADR)
//   mem_ready_i  memory completes the current access this cycle
//   timeout_i    the wait counter has reached its last allowed cycle
//   next_state_o next state encoding
module mc_next_state
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] opcode_q_i,
    input  logic       mem_ready_i,
    input  logic       timeout_i,
    output logic [3:0] next_state_o
);

    state_e cur;
    state_e nxt;

    assign cur          = state_e'(state_i);
    assign next_state_o = nxt;

    // In the three wait states MemReady has priority over the timeout, so a
    // completion on the final allowed cycle still proceeds normally.
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH: begin
                if (mem_ready_i)    nxt = S_DECODE;
                else if (timeout_i) nxt = S_TRAP;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:                    nxt = S_EXEC;
                    OP_LW, OP_SW:                nxt = S_MEMADR;
                    OP_BEQ:                      nxt = S_BRANCH;
                    OP_J:                        nxt = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_ORI, OP_SLTI, OP_LUI:     nxt = S_IEXEC;
                    default:                     nxt = S_TRAP;
                endcase
            end
            S_MEMADR: nxt = (opcode_q_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready_i)    nxt = S_MEMWB;
                else if (timeout_i) nxt = S_TRAP;
            end
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR: begin
                if (mem_ready_i)    nxt = S_FETCH;
                else if (timeout_i) nxt = S_TRAP;
            end
            S_EXEC:   nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_IEXEC:  nxt = S_IWB;
            S_IWB:    nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;   // unused encodings 12..14
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Control FSM for the multicycle MIPS datapath (one shared memory for fetch
// and data). Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath
// select and write enable; traps on an illegal opcode or memory timeout.
// Ports:
//   CLK, Reset_L (sync, active low)
//   Opcode[5:0], Zero, MemReady                      inputs
//   PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
//   RegDst MemToReg RegWrite SignExtend ALUSrcA
//   ALUSrcB[1:0] ALUop[3:0] PCSource[1:0]            datapath controls
//   Trap (sticky), State[STATE_W-1:0] (debug)
//
// Memory handshake: MemRead/MemWrite are held steady for as long as the FSM
// sits in FETCH, MEMRD or MEMWR; the access completes on the first rising
// edge at which MemReady=1, and the FSM leaves the wait state on that edge.
// MemReady seen in any other state is ignored.
module multi_cycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STATE_W     = 4
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               SignExtend,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUop,
    output logic [1:0]         PCSource,
    output logic               Trap,
    output logic [STATE_W-1:0] State
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [3:0]       next_state;
    logic             in_wait;
    logic             timeout;
    logic             fetch_done;

    // Zero is consumed by the datapath (PCWriteCond & Zero), not by the FSM.
    logic unused_zero;
    assign unused_zero = Zero;

    assign in_wait    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // Counter holds the number of earlier wait cycles of this access, so the
    // current cycle is the last one allowed when it equals MEM_TIMEOUT-1.
    assign timeout    = (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign fetch_done = (state_q == S_FETCH) && MemReady;

    mc_next_state u_next_state (
        .state_i      (state_q),
        .opcode_i     (Opcode),
        .opcode_q_i   (opcode_q),
        .mem_ready_i  (MemReady),
        .timeout_i    (timeout),
        .next_state_o (next_state)
    );

    always_comb begin
        state_d  = state_e'(next_state);
        opcode_d = (state_q == S_DECODE) ? Opcode : opcode_q;

        // Any state change (entry into a wait state included) or a completed
        // access restarts the count.
        wait_cnt_d = '0;
        if (in_wait && !MemReady && (state_d == state_q))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);

        // Outputs are registered by decoding the state being entered, so they
        // line up with state_q on the following cycle.
        ctrl_d = decode_ctrl(state_d, opcode_d);
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q    <= S_FETCH;
            opcode_q   <= '0;
            wait_cnt_q <= '0;
            ctrl_q     <= decode_ctrl(S_FETCH, 6'b000000);
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // PC/IR loads in FETCH happen in the cycle the instruction word arrives.
    assign PCWrite     = ctrl_q.pc_write | fetch_done;
    assign IRWrite     = fetch_done;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    assign SignExtend  = ctrl_q.sign_extend;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUop       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign Trap        = ctrl_q.trap;
    assign State       = STATE_W'(state_q);

endmodule
